data_mem_unit: RTL and testbench

//  Byte-addressed, little-endian data memory for the RV32I datapath (MEM stage).

---
 rtl/data_mem_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_data_mem_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// Byte-addressed little-endian RV32I data memory with registered load/store responses.
// Define MISALIGN_TRAP_EN to trap misaligned accesses instead of splitting row crossings.
module data_mem_unit #(
  parameter int A_WIDTH = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int R_WIDTH = A_WIDTH - 2;
  localparam int ROWS    = 1 << R_WIDTH;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SPLIT = 1'b1} state_t;

  state_t r_state, w_state_nxt;

  logic [7:0]         r_mem [0:3][0:ROWS-1];
  logic [1:0]         r_lane;
  logic [2:0]         r_funct3;
  logic               r_we;
  logic [31:0]        r_wdata;
  logic [R_WIDTH-1:0] r_row2;
  logic [31:0]        r_rowbuf;

  logic [1:0]         w_lane;
  logic [R_WIDTH-1:0] w_row;
  logic               w_legal, w_err, w_split, w_accept, w_phase2, w_op_go;
  logic [1:0]         w_op_lane;
  logic [2:0]         w_op_f3, w_op_size;
  logic               w_op_we;
  logic [31:0]        w_op_wdata, w_wlanes, w_raw;
  logic [R_WIDTH-1:0] w_op_row;
  logic [3:0]         w_be;
  logic               w_unused_addr;

  function automatic logic [2:0] size_of(input logic [1:0] code);
    case (code)
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
    case (f3)
      3'b000:  extend = {{24{raw[7]}}, raw[7:0]};
      3'b001:  extend = {{16{raw[15]}}, raw[15:0]};
      3'b010:  extend = raw;
      3'b100:  extend = {24'h000000, raw[7:0]};
      3'b101:  extend = {16'h0000, raw[15:0]};
      default: extend = 32'h0000_0000;
    endcase
  endfunction

  // First pass covers lanes lane..3, second pass the lanes that spilled into the next row.
  function automatic logic lane_en(input logic phase2, input logic [1:0] lane,
                                   input logic [2:0] size, input logic [1:0] j);
    logic [3:0] jj, ll, ss;
    jj = {2'b00, j};
    ll = {2'b00, lane};
    ss = {1'b0, size};
    if (phase2) begin
      lane_en = (jj + 4'd4) < (ll + ss);
    end else begin
      lane_en = (jj >= ll) && ((jj - ll) < ss);
    end
  endfunction

  assign w_lane        = req_addr[1:0];
  assign w_row         = req_addr[A_WIDTH-1:2];
  assign w_accept      = req_valid && req_ready;
  assign w_phase2      = (r_state == ST_SPLIT);
  assign w_unused_addr = ^req_addr[31:A_WIDTH];

  // Request legality, misalignment handling and split detection
  always_comb begin
    case ({req_we, req_funct3})
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
      4'b1000, 4'b1001, 4'b1010: w_legal = 1'b1;
      default:                   w_legal = 1'b0;
    endcase
`ifdef MISALIGN_TRAP_EN
    w_split = 1'b0;
    w_err   = !w_legal
              || (req_funct3[1:0] == 2'b01 && req_addr[0])
              || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    w_split = ({1'b0, w_lane} + size_of(req_funct3[1:0])) > 3'd4;
    w_err   = !w_legal;
`endif
  end

  // Operation for this edge: the held second half while splitting, else the incoming request
  always_comb begin
    if (w_phase2) begin
      w_op_lane  = r_lane;
      w_op_f3    = r_funct3;
      w_op_we    = r_we;
      w_op_wdata = r_wdata;
      w_op_row   = r_row2;
      w_op_go    = 1'b1;
    end else begin
      w_op_lane  = w_lane;
      w_op_f3    = req_funct3;
      w_op_we    = req_we;
      w_op_wdata = req_wdata;
      w_op_row   = w_row;
      w_op_go    = w_accept && !w_err;
    end
    w_op_size = size_of(w_op_f3[1:0]);
  end

  // Lane enables, store data rotation and load byte gathering
  always_comb begin
    logic [1:0] v_k;
    logic [1:0] v_ln;
    v_k      = 2'b00;
    v_ln     = 2'b00;
    w_be     = 4'b0000;
    w_wlanes = 32'h0000_0000;
    w_raw    = 32'h0000_0000;
    for (int j = 0; j < 4; j++) begin
      v_k = 2'(j) - w_op_lane;
      w_be[j] = w_op_go && w_op_we && lane_en(w_phase2, w_op_lane, w_op_size, 2'(j));
      w_wlanes[8*j +: 8] = w_op_wdata[{v_k, 3'b000} +: 8];
    end
    // Bytes still in the first row come from the snapshot taken when the split began
    for (int k = 0; k < 4; k++) begin
      v_ln = w_op_lane + 2'(k);
      if (w_phase2 && (({1'b0, w_op_lane} + 3'(k)) < 3'd4)) begin
        w_raw[8*k +: 8] = r_rowbuf[{v_ln, 3'b000} +: 8];
      end else begin
        w_raw[8*k +: 8] = r_mem[v_ln][w_op_row];
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_op_go && w_split) begin
          w_state_nxt = ST_SPLIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SPLIT: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign req_ready = 1'b1;
`else
  assign req_ready = (r_state == ST_IDLE);
`endif

  // Byte-lane storage, deliberately not reset
  always_ff @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      if (w_be[j]) begin
        r_mem[j][w_op_row] <= w_wlanes[8*j +: 8];
      end
    end
  end

  // FSM state and context held across the split
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_lane   <= 2'b00;
      r_funct3 <= 3'b000;
      r_we     <= 1'b0;
      r_wdata  <= 32'h0000_0000;
      r_row2   <= '0;
      r_rowbuf <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      if (!w_phase2 && w_op_go && w_split) begin
        r_lane   <= w_lane;
        r_funct3 <= req_funct3;
        r_we     <= req_we;
        r_wdata  <= req_wdata;
        r_row2   <= w_row + R_WIDTH'(1);
        r_rowbuf <= {r_mem[3][w_row], r_mem[2][w_row], r_mem[1][w_row], r_mem[0][w_row]};
      end
    end
  end

  // Registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0000_0000;
      rsp_err   <= 1'b0;
    end else if (w_phase2) begin
      rsp_valid <= 1'b1;
      rsp_err   <= 1'b0;
      rsp_rdata <= w_op_we ? 32'h0000_0000 : extend(w_op_f3, w_raw);
    end else if (w_accept && w_err) begin
      rsp_valid <= 1'b1;
      rsp_err   <= 1'b1;
      rsp_rdata <= 32'h0000_0000;
    end else if (w_accept && !w_split) begin
      rsp_valid <= 1'b1;
      rsp_err   <= 1'b0;
      rsp_rdata <= w_op_we ? 32'h0000_0000 : extend(w_op_f3, w_raw);
    end else begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed self-checking bench for data_mem_unit (A_WIDTH=12 so the wrap case is reachable).
// Expectations follow MISALIGN_TRAP_EN when it is defined for the build.
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  data_mem_unit #(.A_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic set_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  // One request, then wait (bounded) for its response and check latency, data and error flag
  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
    int lat;
    @(negedge clk);
    check_eq({tag, "_idle"}, {31'b0, rsp_valid}, 32'd0);
    set_req(we, f3, addr, wdata);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    if (exp_lat == 2) check_eq({tag, "_busy"}, {31'b0, req_ready}, 32'd0);
    while (!rsp_valid && lat < 4) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_data"}, rsp_rdata, exp_d);
    check_eq({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_e});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rst_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'd0);
    check_eq("rst_err", {31'b0, rsp_err}, 32'd0);
    rst_n = 1'b1;

    txn("sw100",  1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 1);
    txn("lw100",  1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1);
    txn("lb103",  1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFFDE, 1'b0, 1);
    txn("lbu103", 1'b0, 3'b100, 32'h103, 32'h0, 32'h000000DE, 1'b0, 1);

    txn("sh102",  1'b1, 3'b001, 32'h102, 32'h00008001, 32'h0, 1'b0, 1);
    txn("lw_mrg", 1'b0, 3'b010, 32'h100, 32'h0, 32'h8001BEEF, 1'b0, 1);
    txn("lh102",  1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF8001, 1'b0, 1);
    txn("lhu102", 1'b0, 3'b101, 32'h102, 32'h0, 32'h00008001, 1'b0, 1);

    txn("sw0fc",  1'b1, 3'b010, 32'h0FC, 32'h11223344, 32'h0, 1'b0, 1);
    txn("sw100b", 1'b1, 3'b010, 32'h100, 32'h55667788, 32'h0, 1'b0, 1);
`ifdef MISALIGN_TRAP_EN
    txn("lw0fe",  1'b0, 3'b010, 32'h0FE, 32'h0, 32'h0, 1'b1, 1);
    txn("lh101",  1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 1'b1, 1);
    txn("swfffe", 1'b1, 3'b010, 32'hFFE, 32'hA1B2C3D4, 32'h0, 1'b1, 1);
`else
    txn("lw0fe",  1'b0, 3'b010, 32'h0FE, 32'h0, 32'h77881122, 1'b0, 2);
    txn("lh101",  1'b0, 3'b001, 32'h101, 32'h0, 32'h00006677, 1'b0, 1);
    txn("swfffe", 1'b1, 3'b010, 32'hFFE, 32'hA1B2C3D4, 32'h0, 1'b0, 2);
    txn("lbuffe", 1'b0, 3'b100, 32'hFFE, 32'h0, 32'h000000D4, 1'b0, 1);
    txn("lbufff", 1'b0, 3'b100, 32'hFFF, 32'h0, 32'h000000C3, 1'b0, 1);
    txn("lbu000", 1'b0, 3'b100, 32'h000, 32'h0, 32'h000000B2, 1'b0, 1);
    txn("lbu001", 1'b0, 3'b100, 32'h001, 32'h0, 32'h000000A1, 1'b0, 1);
`endif

    txn("ill_st", 1'b1, 3'b011, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
    txn("ill_lw", 1'b0, 3'b010, 32'h100, 32'h0, 32'h55667788, 1'b0, 1);
    txn("ill_ld", 1'b0, 3'b111, 32'h100, 32'h0, 32'h0, 1'b1, 1);

    // Back-to-back aligned loads: one response per cycle
    @(negedge clk);
    set_req(1'b0, 3'b010, 32'h0FC, 32'h0);
    @(negedge clk);
    check_eq("b2b0_v", {31'b0, rsp_valid}, 32'd1);
    check_eq("b2b0_d", rsp_rdata, 32'h11223344);
    set_req(1'b0, 3'b010, 32'h100, 32'h0);
    @(negedge clk);
    check_eq("b2b1_v", {31'b0, rsp_valid}, 32'd1);
    check_eq("b2b1_d", rsp_rdata, 32'h55667788);
    set_req(1'b0, 3'b100, 32'h0FF, 32'h0);
    @(negedge clk);
    check_eq("b2b2_v", {31'b0, rsp_valid}, 32'd1);
    check_eq("b2b2_d", rsp_rdata, 32'h00000011);
    req_valid = 1'b0;

`ifndef MISALIGN_TRAP_EN
    // Reset while splitting: only the first-row half of the store survives
    @(negedge clk);
    set_req(1'b1, 3'b010, 32'h0FE, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rsp_busy", {31'b0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("rsp_noval", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rsp_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rsp_noval2", {31'b0, rsp_valid}, 32'd0);
    txn("rst_lo", 1'b0, 3'b010, 32'h0FC, 32'h0, 32'hF00D3344, 1'b0, 1);
    txn("rst_hi", 1'b0, 3'b010, 32'h100, 32'h0, 32'h55667788, 1'b0, 1);
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
